// File: rtl/hazard_ctrl_if.sv
// Decode/EX-side control bundle between the core datapath and hazard_ctrl.
// The master is the core and drives decode info and redirect. The slave is hazard_ctrl and returns the pipeline controls.
interface hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        ex_redirect;
  logic        stall;
  logic        bubble;
  logic        squash;
  logic [31:0] busy;
  logic [15:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, ex_redirect,
    input  stall, bubble, squash, busy, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, ex_redirect,
    output stall, bubble, squash, busy, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: write scoreboard, RAW stall, redirect squash.
// Optional macro HAZARD_WB_BYPASS_EN: the WB entry is not counted as a hazard because the register file writes before it reads.
module hazard_ctrl #(
  parameter int DEPTH         = 3,
  parameter int SQUASH_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz_if
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [1:0] FCNT_RELOAD = (SQUASH_CYCLES > 0) ? 2'(SQUASH_CYCLES - 1) : 2'd0;
  localparam logic       HAS_FLUSH   = (SQUASH_CYCLES > 0);

`ifdef HAZARD_WB_BYPASS_EN
  localparam logic [DEPTH-1:0] HIT_MASK = {1'b0, {(DEPTH-1){1'b1}}};
`else
  localparam logic [DEPTH-1:0] HIT_MASK = {DEPTH{1'b1}};
`endif

  state_e          state_q, state_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]      rd_q [DEPTH];
  logic [4:0]      rd_d [DEPTH];
  logic [15:0]     stall_count_q, stall_count_d;

  logic            squash_s;
  logic            rs1_hit_s;
  logic            rs2_hit_s;
  logic            hazard_s;
  logic            stall_s;
  logic [31:0]     busy_s;

  // Source-operand match against in-flight writers
  always_comb begin
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rs1_hit_s = rs1_hit_s | (HIT_MASK[i] & vld_q[i] & (rd_q[i] == hz_if.id_rs1));
      rs2_hit_s = rs2_hit_s | (HIT_MASK[i] & vld_q[i] & (rd_q[i] == hz_if.id_rs2));
    end
  end

  assign hazard_s = hz_if.id_valid & ~squash_s &
                    ((hz_if.id_use_rs1 & (hz_if.id_rs1 != 5'd0) & rs1_hit_s) |
                     (hz_if.id_use_rs2 & (hz_if.id_rs2 != 5'd0) & rs2_hit_s));
  assign stall_s  = hazard_s & ~squash_s;

  // Redirect sequencing: squash the redirect cycle plus the fetch-latency shadow
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    squash_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz_if.ex_redirect) begin
          squash_s = 1'b1;
          if (HAS_FLUSH) begin
            state_d = ST_FLUSH;
            fcnt_d  = FCNT_RELOAD;
          end else begin
            state_d = ST_RUN;
            fcnt_d  = 2'd0;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        squash_s = 1'b1;
        if (hz_if.ex_redirect) begin
          fcnt_d = FCNT_RELOAD;
        end else if (fcnt_q == 2'd0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = 2'd0;
      end
    endcase
  end

  // Scoreboard shift; a stalled, squashed or wrong-path decode enters EX as a bubble
  always_comb begin
    vld_d    = '0;
    vld_d[0] = hz_if.id_valid & hz_if.id_reg_write & (hz_if.id_rd != 5'd0) &
               ~stall_s & ~squash_s;
    rd_d[0]  = hz_if.id_rd;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      rd_d[i]  = rd_q[i-1];
    end
  end

  // Pending-write vector; x0 never reported
  always_comb begin
    busy_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_s = busy_s | ({31'd0, vld_q[i]} << rd_q[i]);
    end
    busy_s[0] = 1'b0;
  end

  // Saturating stall counter
  always_comb begin
    if (stall_s && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      fcnt_q        <= 2'd0;
      vld_q         <= '0;
      stall_count_q <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= 5'd0;
      end
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      vld_q         <= vld_d;
      stall_count_q <= stall_count_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= rd_d[i];
      end
    end
  end

  assign hz_if.stall       = stall_s;
  assign hz_if.bubble      = stall_s | squash_s;
  assign hz_if.squash      = squash_s;
  assign hz_if.busy        = busy_s;
  assign hz_if.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: dut1 uses SQUASH_CYCLES=1 and dut2 uses SQUASH_CYCLES=2.
// Both instances receive the same stimulus.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

`ifdef HAZARD_WB_BYPASS_EN
  localparam int RAW_STALLS = 2;
`else
  localparam int RAW_STALLS = 3;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_if if1 ();
  hazard_ctrl_if if2 ();

  hazard_ctrl #(.DEPTH(3), .SQUASH_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .hz_if(if1));
  hazard_ctrl #(.DEPTH(3), .SQUASH_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .hz_if(if2));

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic redir);
    if1.id_valid = v;  if1.id_rs1 = rs1; if1.id_rs2 = rs2; if1.id_use_rs1 = u1;
    if1.id_use_rs2 = u2; if1.id_rd = rd; if1.id_reg_write = rw; if1.ex_redirect = redir;
    if2.id_valid = v;  if2.id_rs1 = rs1; if2.id_rs2 = rs2; if2.id_use_rs1 = u1;
    if2.id_use_rs2 = u2; if2.id_rd = rd; if2.id_reg_write = rw; if2.ex_redirect = redir;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (if1.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", if1.stall); end
    checks++; if (if1.bubble !== 1'b0) begin failures++; $display("FAIL reset_bubble got=%b exp=0", if1.bubble); end
    checks++; if (if1.squash !== 1'b0) begin failures++; $display("FAIL reset_squash got=%b exp=0", if1.squash); end
    checks++; if (if1.busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", if1.busy); end
    checks++; if (if1.stall_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", if1.stall_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_raw_stall();
    logic exp_s;
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5,x0,1
    @(negedge clk);
    checks++; if (if1.stall !== 1'b0) begin failures++; $display("FAIL raw_producer_stall got=%b exp=0", if1.stall); end
    tick();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
    for (int i = 0; i <= RAW_STALLS; i++) begin
      @(negedge clk);
      exp_s = (i < RAW_STALLS);
      checks++; if (if1.stall !== exp_s) begin failures++; $display("FAIL raw_stall_c%0d got=%b exp=%b", i, if1.stall, exp_s); end
      checks++; if (if1.bubble !== exp_s) begin failures++; $display("FAIL raw_bubble_c%0d got=%b exp=%b", i, if1.bubble, exp_s); end
      if (i == 0) begin
        checks++; if (if1.busy !== 32'h0000_0020) begin failures++; $display("FAIL raw_busy got=%h exp=00000020", if1.busy); end
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++; if (if1.stall_count !== 16'(RAW_STALLS)) begin failures++; $display("FAIL raw_count got=%0d exp=%0d", if1.stall_count, RAW_STALLS); end
    checks++; if (if1.busy !== 32'h0000_0040) begin failures++; $display("FAIL raw_busy_after got=%h exp=00000040", if1.busy); end
    repeat (4) tick();
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);   // addi x0,x0,1
    @(negedge clk);
    checks++; if (if1.stall !== 1'b0) begin failures++; $display("FAIL x0_prod_stall got=%b exp=0", if1.stall); end
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);   // add x1,x0,x0
    @(negedge clk);
    checks++; if (if1.stall !== 1'b0) begin failures++; $display("FAIL x0_cons_stall got=%b exp=0", if1.stall); end
    checks++; if (if1.busy !== 32'd0) begin failures++; $display("FAIL x0_busy got=%h exp=0", if1.busy); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (if1.busy !== 32'h0000_0002) begin failures++; $display("FAIL x0_busy_x1 got=%h exp=00000002", if1.busy); end
    checks++; if (if1.stall_count !== 16'(RAW_STALLS)) begin failures++; $display("FAIL x0_count got=%0d exp=%0d", if1.stall_count, RAW_STALLS); end
    repeat (4) tick();
  endtask

  task automatic test_redirect_squash();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5
    tick();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1);   // add x7,x5,x5 with redirect
    @(negedge clk);
    checks++; if (if1.squash !== 1'b1) begin failures++; $display("FAIL redir_squash_c0 got=%b exp=1", if1.squash); end
    checks++; if (if1.stall !== 1'b0) begin failures++; $display("FAIL redir_stall_c0 got=%b exp=0", if1.stall); end
    checks++; if (if1.bubble !== 1'b1) begin failures++; $display("FAIL redir_bubble_c0 got=%b exp=1", if1.bubble); end
    checks++; if (if1.busy !== 32'h0000_0020) begin failures++; $display("FAIL redir_busy_c0 got=%h exp=00000020", if1.busy); end
    tick();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (if1.squash !== 1'b1) begin failures++; $display("FAIL redir_squash_c1 got=%b exp=1", if1.squash); end
    checks++; if (if1.stall !== 1'b0) begin failures++; $display("FAIL redir_stall_c1 got=%b exp=0", if1.stall); end
    checks++; if (if1.busy !== 32'h0000_0020) begin failures++; $display("FAIL redir_busy_c1 got=%h exp=00000020", if1.busy); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (if1.squash !== 1'b0) begin failures++; $display("FAIL redir_squash_c2 got=%b exp=0", if1.squash); end
    checks++; if (if1.busy !== 32'h0000_0020) begin failures++; $display("FAIL redir_busy_c2 got=%h exp=00000020", if1.busy); end
    tick();
    @(negedge clk);
    checks++; if (if1.busy !== 32'd0) begin failures++; $display("FAIL redir_busy_c3 got=%h exp=0", if1.busy); end
    checks++; if (if1.stall_count !== 16'(RAW_STALLS)) begin failures++; $display("FAIL redir_count got=%0d exp=%0d", if1.stall_count, RAW_STALLS); end
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp1;
    logic [5:0] exp2;
    exp1 = 6'b00_0111;
    exp2 = 6'b00_1111;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, (c < 2));
      @(negedge clk);
      checks++; if (if1.squash !== exp1[c]) begin failures++; $display("FAIL b2b_sq1_c%0d got=%b exp=%b", c, if1.squash, exp1[c]); end
      checks++; if (if2.squash !== exp2[c]) begin failures++; $display("FAIL b2b_sq2_c%0d got=%b exp=%b", c, if2.squash, exp2[c]); end
      checks++; if (if2.stall !== 1'b0) begin failures++; $display("FAIL b2b_stall_c%0d got=%b exp=0", c, if2.stall); end
      tick();
    end
    idle();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (if1.stall !== 1'b1) begin failures++; $display("FAIL mid_prestall got=%b exp=1", if1.stall); end
    #2 rst = 1'b1;
    #1;
    checks++; if (if1.stall !== 1'b0) begin failures++; $display("FAIL mid_stall got=%b exp=0", if1.stall); end
    checks++; if (if1.bubble !== 1'b0) begin failures++; $display("FAIL mid_bubble got=%b exp=0", if1.bubble); end
    checks++; if (if1.squash !== 1'b0) begin failures++; $display("FAIL mid_squash got=%b exp=0", if1.squash); end
    checks++; if (if1.busy !== 32'd0) begin failures++; $display("FAIL mid_busy got=%h exp=0", if1.busy); end
    checks++; if (if1.stall_count !== 16'd0) begin failures++; $display("FAIL mid_count got=%h exp=0", if1.stall_count); end
    #1 rst = 1'b0;
    tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    idle();
    @(negedge clk);
    checks++; if (if1.squash !== 1'b1) begin failures++; $display("FAIL flush_pre got=%b exp=1", if1.squash); end
    #2 rst = 1'b1;
    #1;
    checks++; if (if1.squash !== 1'b0) begin failures++; $display("FAIL flush_rst_squash got=%b exp=0", if1.squash); end
    checks++; if (if2.bubble !== 1'b0) begin failures++; $display("FAIL flush_rst_bubble got=%b exp=0", if2.bubble); end
    #1 rst = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (if1.squash !== 1'b0) begin failures++; $display("FAIL flush_resume1 got=%b exp=0", if1.squash); end
    checks++; if (if2.squash !== 1'b0) begin failures++; $display("FAIL flush_resume2 got=%b exp=0", if2.squash); end
    tick();
  endtask

  task automatic test_saturate();
    idle();
    @(negedge clk);
    checks++; if (if1.stall_count !== 16'd0) begin failures++; $display("FAIL sat_start got=%h exp=0", if1.stall_count); end
    tick();
    force u_dut1.hazard_s = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    checks++; if (if1.stall !== 1'b1) begin failures++; $display("FAIL sat_stall got=%b exp=1", if1.stall); end
    checks++; if (if1.stall_count !== 16'hFFFE) begin failures++; $display("FAIL sat_fffe got=%h exp=fffe", if1.stall_count); end
    repeat (4466) @(posedge clk);
    @(negedge clk);
    checks++; if (if1.stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", if1.stall_count); end
    #1 release u_dut1.hazard_s;
    #1;
    checks++; if (if1.stall !== 1'b0) begin failures++; $display("FAIL sat_release got=%b exp=0", if1.stall); end
    tick();
    @(negedge clk);
    checks++; if (if1.stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_final got=%h exp=ffff", if1.stall_count); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_raw_stall();
    test_x0();
    test_redirect_squash();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the single-issue RISC-V core. Tracks in-flight register writes in a scoreboard, stalls decode on read-after-write hazards, and squashes wrong-path instructions after a branch/jump redirect resolved in EX. Sits beside the core datapath and drives its PC-hold, bubble-insert and kill controls; replaces the ad-hoc `do_branch` delay-line gating.

## Interface
- `DEPTH`, 3: pipeline stages between decode and register-file write (EX, MEM, WB).
- `SQUASH_CYCLES`, 1: extra cycles squashed after a redirect, covering synchronous instruction-memory latency; range 0–3.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: decode stage holds a real instruction.
- `id_rs1`, `id_rs2` in 5 each: source register indices.
- `id_use_rs1`, `id_use_rs2` in 1 each: instruction actually reads that source.
- `id_rd` in 5: destination index.
- `id_reg_write` in 1: instruction writes `id_rd`.
- `ex_redirect` in 1: taken branch/JAL/JALR resolved in EX this cycle.
- `stall` out 1: hold PC and IF/ID register; combinational.
- `bubble` out 1: inject NOP into EX (clear all EX control bits); combinational.
- `squash` out 1: kill instruction in IF/ID and the one being fetched; combinational.
- `busy` out 32: one bit per register with a pending write; bit 0 always 0.
- `stall_count` out 16: saturating count of cycles with `stall`=1.

## Operation
- Scoreboard: DEPTH entries `{vld, rd}`; entry 0 = EX, entry DEPTH-1 = WB. Shifts every cycle; entry DEPTH-1 retires.
- Entry 0 loads `{id_valid & id_reg_write & (id_rd!=0) & ~stall & ~squash, id_rd}`; otherwise `vld`=0.
- On `ex_redirect`, entry 0's incoming instruction is wrong-path: loaded invalid. The redirecting instruction (already in EX) keeps its entry.
- Hazard: `id_valid & ~squash` and (`id_use_rs1` & rs1≠0 & match) or (`id_use_rs2` & rs2≠0 & match); match = any valid entry 0..DEPTH-2 with equal rd, plus entry DEPTH-1 unless bypass configured.
- `stall` = hazard & ~`squash`; `bubble` = `stall` | `squash`.
- `busy` = OR of decoded valid entries (including DEPTH-1).
- FSM states RUN, FLUSH; counter `fcnt` (2 bits).
  - RUN: `ex_redirect` → `squash`=1 this cycle; if SQUASH_CYCLES>0 go FLUSH with `fcnt`=SQUASH_CYCLES-1, else stay RUN.
  - FLUSH: `squash`=1; `fcnt`=0 → RUN, else decrement. A new `ex_redirect` in FLUSH reloads `fcnt`=SQUASH_CYCLES-1 and stays.
- Priority: redirect/squash over stall; stall never asserted while `squash`=1.
- `stall_count` increments when `stall`=1, saturates at 16'hFFFF.

## Timing
- Reset: all entries invalid, state RUN, `fcnt`=0, `stall_count`=0; hence `stall`=`bubble`=`squash`=0, `busy`=0.
- Reset deassertion mid-flush or mid-stall: resumes clean in RUN, no residual squash.
- Stall → release latency: producer in EX stalls consumer for DEPTH-1 cycles (DEPTH with bypass off… see Configuration).
- `squash` active in redirect cycle plus SQUASH_CYCLES following cycles.
- Outputs depend combinationally only on inputs and registered state; no combinational path from `ex_redirect` to scoreboard contents.

## Configuration
- `HAZARD_WB_BYPASS_EN` defined: register file writes before read in the same cycle; entry DEPTH-1 excluded from hazard match; dependent instruction behind EX producer stalls DEPTH-1 = 2 cycles.
- Not defined: entry DEPTH-1 included; same case stalls DEPTH = 3 cycles. `busy` unaffected.

## Test plan
- Reset asserted mid-stall (x5 pending, consumer waiting) → same cycle all outputs 0, `busy`=0, `stall_count`=0.
- `addi x5` then dependent `add x6,x5,x5` back-to-back, bypass on → `stall`=1 for exactly 2 cycles, 2 bubbles, `stall_count`=2; bypass off → 3 cycles, count 3.
- Producer/consumer on x0 (`addi x0`; `add x1,x0,x0`) → `stall` never asserted, `busy[0]`=0.
- `ex_redirect` pulse with SQUASH_CYCLES=1 while decode holds a hazarded instruction → `squash`=1 for 2 cycles, `stall`=0 both, wrong-path write to x7 never appears in `busy`.
- Two redirects 1 cycle apart, SQUASH_CYCLES=2 → `squash` continuous for 4 cycles, then RUN.
- Force 70000 consecutive stall cycles → `stall_count` holds 16'hFFFF, no wrap.
